// File: rtl/order_issue_ctrl.sv
// AXI-Lite master that drains a FIFO of {addr, data} orders into single register writes.
// Writes to GATE_ADDR wait for STATUS_ADDR to read non-zero; ORDER_POLL_TIMEOUT_EN bounds that wait.
//
// state   | meaning
// IDLE    | waiting for an order at the FIFO head
// POLL_AR | status read address in flight
// POLL_R  | waiting for status read data
// WR      | AW and W of the head order in flight
// WAIT_B  | waiting for the write response; head pops here
module order_issue_ctrl #(
    parameter int                         AXIL_DATA_WIDTH = 32,
    parameter int                         AXIL_ADDR_WIDTH = 8,
    parameter int                         FIFO_DEPTH      = 4,
    parameter logic [AXIL_ADDR_WIDTH-1:0] GATE_ADDR       = 8'h48,
    parameter logic [AXIL_ADDR_WIDTH-1:0] STATUS_ADDR     = 8'h4c,
    parameter int                         POLL_LIMIT      = 1024
) (
    input  logic                         m00_axi_aclk,
    input  logic                         m00_axi_aresetn,
    input  logic                         ord_valid,
    output logic                         ord_ready,
    input  logic [AXIL_ADDR_WIDTH-1:0]   ord_addr,
    input  logic [AXIL_DATA_WIDTH-1:0]   ord_data,
    output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_awaddr,
    output logic [2:0]                   m00_axi_awprot,
    output logic                         m00_axi_awvalid,
    input  logic                         m00_axi_awready,
    output logic [AXIL_DATA_WIDTH-1:0]   m00_axi_wdata,
    output logic [AXIL_DATA_WIDTH/8-1:0] m00_axi_wstrb,
    output logic                         m00_axi_wvalid,
    input  logic                         m00_axi_wready,
    input  logic [1:0]                   m00_axi_bresp,
    input  logic                         m00_axi_bvalid,
    output logic                         m00_axi_bready,
    output logic [AXIL_ADDR_WIDTH-1:0]   m00_axi_araddr,
    output logic [2:0]                   m00_axi_arprot,
    output logic                         m00_axi_arvalid,
    input  logic                         m00_axi_arready,
    input  logic [AXIL_DATA_WIDTH-1:0]   m00_axi_rdata,
    input  logic [1:0]                   m00_axi_rresp,
    input  logic                         m00_axi_rvalid,
    output logic                         m00_axi_rready,
    output logic                         busy,
    output logic                         err,
    output logic [15:0]                  issued_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || POLL_LIMIT < 1) begin : g_param_check
        $error("order_issue_ctrl: FIFO_DEPTH must be a power of two >= 2 and POLL_LIMIT >= 1");
    end

    typedef enum logic [2:0] {IDLE, POLL_AR, POLL_R, WR, WAIT_B} state_t;

    state_t state;

    logic [AXIL_ADDR_WIDTH-1:0] fifo_addr [FIFO_DEPTH];
    logic [AXIL_DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           count;
    logic                       fifo_empty;
    logic                       push;
    logic                       pop;
    logic [AXIL_ADDR_WIDTH-1:0] head_addr;
    logic [AXIL_DATA_WIDTH-1:0] head_data;
    logic                       aw_done;
    logic                       w_done;

    assign ord_ready  = (count != CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push       = ord_valid && ord_ready;
    assign head_addr  = fifo_addr[rd_ptr];
    assign head_data  = fifo_data[rd_ptr];
    assign busy       = !fifo_empty || (state != IDLE);

    assign m00_axi_awprot = 3'b000;
    assign m00_axi_arprot = 3'b000;
    assign m00_axi_wstrb  = '1;
    assign m00_axi_araddr = STATUS_ADDR;

    assign aw_done = !m00_axi_awvalid || m00_axi_awready;
    assign w_done  = !m00_axi_wvalid || m00_axi_wready;

`ifdef ORDER_POLL_TIMEOUT_EN
    localparam int POLL_W = $clog2(POLL_LIMIT + 1);

    // Reads remaining for the current gate; expiry is the last allowed read returning zero.
    logic [POLL_W-1:0] poll_left;
    logic              poll_expire;

    assign poll_expire = (state == POLL_R) && m00_axi_rvalid && (m00_axi_rdata == '0)
                         && (poll_left == POLL_W'(1));
`endif

    always_comb begin
        pop = m00_axi_bready && m00_axi_bvalid;
`ifdef ORDER_POLL_TIMEOUT_EN
        if (poll_expire) begin
            pop = 1'b1;
        end
`endif
    end

    always_ff @(posedge m00_axi_aclk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= ord_addr;
            fifo_data[wr_ptr] <= ord_data;
        end
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge m00_axi_aclk or negedge m00_axi_aresetn) begin
        if (!m00_axi_aresetn) begin
            state           <= IDLE;
            m00_axi_awaddr  <= '0;
            m00_axi_awvalid <= 1'b0;
            m00_axi_wdata   <= '0;
            m00_axi_wvalid  <= 1'b0;
            m00_axi_bready  <= 1'b0;
            m00_axi_arvalid <= 1'b0;
            m00_axi_rready  <= 1'b0;
            err             <= 1'b0;
            issued_cnt      <= '0;
`ifdef ORDER_POLL_TIMEOUT_EN
            poll_left       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        if (head_addr == GATE_ADDR) begin
                            state           <= POLL_AR;
                            m00_axi_arvalid <= 1'b1;
`ifdef ORDER_POLL_TIMEOUT_EN
                            poll_left       <= POLL_W'(POLL_LIMIT);
`endif
                        end else begin
                            state           <= WR;
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            m00_axi_awaddr  <= head_addr;
                            m00_axi_wdata   <= head_data;
                        end
                    end
                end
                POLL_AR: begin
                    if (m00_axi_arready) begin
                        m00_axi_arvalid <= 1'b0;
                        m00_axi_rready  <= 1'b1;
                        state           <= POLL_R;
                    end
                end
                POLL_R: begin
                    if (m00_axi_rvalid) begin
                        m00_axi_rready <= 1'b0;
                        if (m00_axi_rresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        if (m00_axi_rdata != '0) begin
                            state           <= WR;
                            m00_axi_awvalid <= 1'b1;
                            m00_axi_wvalid  <= 1'b1;
                            m00_axi_awaddr  <= head_addr;
                            m00_axi_wdata   <= head_data;
                        end else begin
`ifdef ORDER_POLL_TIMEOUT_EN
                            if (poll_left == POLL_W'(1)) begin
                                err   <= 1'b1;
                                state <= IDLE;
                            end else begin
                                state           <= POLL_AR;
                                m00_axi_arvalid <= 1'b1;
                                poll_left       <= poll_left - POLL_W'(1);
                            end
`else
                            state           <= POLL_AR;
                            m00_axi_arvalid <= 1'b1;
`endif
                        end
                    end
                end
                WR: begin
                    if (m00_axi_awvalid && m00_axi_awready) begin
                        m00_axi_awvalid <= 1'b0;
                    end
                    if (m00_axi_wvalid && m00_axi_wready) begin
                        m00_axi_wvalid <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state          <= WAIT_B;
                        m00_axi_bready <= 1'b1;
                    end
                end
                WAIT_B: begin
                    if (m00_axi_bvalid) begin
                        m00_axi_bready <= 1'b0;
                        issued_cnt     <= issued_cnt + 16'd1;
                        if (m00_axi_bresp != 2'b00) begin
                            err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
